// File: rtl/ecc_apb_master.sv
// rtl/ecc_apb_master.sv - APB write sequencer that programs the ECC register bank per job and returns the result
module ecc_apb_master #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL     = 'h0,
    parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN  = 'h4,
    parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_CW_WIDTH = 'h8,
    parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE    = 'hC,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [1:0]                 job_ctrl,
    input  logic [AMBA_WORD-1:0]       job_data,
    input  logic [AMBA_WORD-1:0]       job_width,
    input  logic [DATA_WIDTH-1:0]      job_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [1:0]                 res_num_err,
    output logic                       res_timeout
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETUP     = 3'd1;
    localparam logic [2:0] S_ACCESS    = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state;
    logic [1:0]            idx;
    logic                  is_fc;
    logic [1:0]            ctrl_q;
    logic [AMBA_WORD-1:0]  width_q;
    logic [DATA_WIDTH-1:0] noise_q;
    logic [CNT_W-1:0]      cnt;

    logic [1:0]                 next_idx;
    logic [1:0]                 last_idx;
    logic [AMBA_ADDR_WIDTH-1:0] next_addr;
    logic [AMBA_WORD-1:0]       next_data;

    // Write list after DATA_IN: CW_WIDTH, then NOISE for FC jobs, and CTRL always last
    always_comb begin
        next_idx  = idx + 2'd1;
        last_idx  = is_fc ? 2'd3 : 2'd2;
        next_addr = ADDR_CTRL;
        next_data = AMBA_WORD'(ctrl_q);
        case (next_idx)
            2'd1: begin
                next_addr = ADDR_CW_WIDTH;
                next_data = width_q;
            end
            2'd2: begin
                if (is_fc) begin
                    next_addr = ADDR_NOISE;
                    next_data = AMBA_WORD'(noise_q);
                end
            end
            default: ;
        endcase
    end

    // Job sequencing FSM; every output is a register updated on the transition into its state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= 2'd0;
            is_fc       <= 1'b0;
            ctrl_q      <= 2'd0;
            width_q     <= '0;
            noise_q     <= '0;
            cnt         <= '0;
            job_ready   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_num_err <= 2'd0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        ctrl_q    <= job_ctrl;
                        is_fc     <= (job_ctrl == 2'd2);
                        width_q   <= job_width;
                        noise_q   <= job_noise;
                        idx       <= 2'd0;
                        job_ready <= 1'b0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b1;
                        PADDR     <= ADDR_DATA_IN;
                        PWDATA    <= job_data;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (idx == last_idx) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        cnt     <= '0;
                        state   <= S_WAIT_DONE;
                    end else begin
                        idx     <= next_idx;
                        PENABLE <= 1'b0;
                        PADDR   <= next_addr;
                        PWDATA  <= next_data;
                        state   <= S_SETUP;
                    end
                end
                S_WAIT_DONE: begin
                    // A completion on the final timeout cycle still counts as success
                    if (operation_done) begin
                        res_valid   <= 1'b1;
                        res_data    <= data_out;
                        res_num_err <= num_of_errors;
                        res_timeout <= 1'b0;
                        state       <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        res_valid   <= 1'b1;
                        res_data    <= '0;
                        res_num_err <= 2'd0;
                        res_timeout <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    job_ready <= 1'b1;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    PWRITE    <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_apb_master.sv
// tb/tb_ecc_apb_master.sv - self-checking bench for ecc_apb_master
module tb_ecc_apb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [1:0]  job_ctrl = 2'd0;
    logic [31:0] job_data = 32'd0;
    logic [31:0] job_width = 32'd0;
    logic [31:0] job_noise = 32'd0;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        operation_done = 1'b0;
    logic [31:0] data_out = 32'd0;
    logic [1:0]  num_of_errors = 2'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [1:0]  res_num_err;
    logic        res_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int TIMEOUT = 64;

    ecc_apb_master dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_ctrl(job_ctrl),
        .job_data(job_data), .job_width(job_width), .job_noise(job_noise),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_num_err(res_num_err), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete job: expected APB writes come from the register list for the job kind,
    // done_at is the WAIT_DONE cycle carrying operation_done (>= TIMEOUT means never)
    task automatic run_job(input logic [1:0] ctrl, input logic [31:0] data, input logic [31:0] width,
                           input logic [31:0] noise, input int done_at, input logic [31:0] dout,
                           input logic [1:0] nerr, input int stall);
        logic [19:0] wa[$];
        logic [31:0] wd[$];
        logic [31:0] exp_data;
        logic [1:0]  exp_nerr;
        logic        exp_to;
        int          end_w;
        wa.push_back(20'h4); wd.push_back(data);
        wa.push_back(20'h8); wd.push_back(width);
        if (ctrl == 2'd2) begin
            wa.push_back(20'hC); wd.push_back(noise);
        end
        wa.push_back(20'h0); wd.push_back({30'd0, ctrl});

        if (done_at < TIMEOUT) begin
            end_w = done_at; exp_data = dout; exp_nerr = nerr; exp_to = 1'b0;
        end else begin
            end_w = TIMEOUT - 1; exp_data = 32'd0; exp_nerr = 2'd0; exp_to = 1'b1;
        end

        @(negedge clk);
        check("idle_job_ready", {31'd0, job_ready}, 32'd1);
        check("idle_psel", {31'd0, PSEL}, 32'd0);
        job_valid = 1'b1; job_ctrl = ctrl; job_data = data; job_width = width; job_noise = noise;

        for (int k = 0; k < 2 * wa.size(); k++) begin
            @(negedge clk);
            job_valid = 1'b0;
            job_data = $urandom; job_width = $urandom; job_noise = $urandom; job_ctrl = 2'($urandom);
            check("apb_psel", {31'd0, PSEL}, 32'd1);
            check("apb_penable", {31'd0, PENABLE}, 32'(k % 2));
            check("apb_pwrite", {31'd0, PWRITE}, 32'd1);
            check("apb_paddr", {12'd0, PADDR}, {12'd0, wa[k/2]});
            check("apb_pwdata", PWDATA, wd[k/2]);
            check("busy_job_ready", {31'd0, job_ready}, 32'd0);
            // operation_done during the APB phase must be ignored
            operation_done = ($urandom_range(0, 3) == 0);
            data_out = $urandom;
        end

        for (int w = 0; w <= end_w; w++) begin
            @(negedge clk);
            check("wait_psel", {31'd0, PSEL}, 32'd0);
            check("wait_res_valid", {31'd0, res_valid}, 32'd0);
            if (w == done_at) begin
                operation_done = 1'b1; data_out = dout; num_of_errors = nerr;
            end else begin
                operation_done = 1'b0; data_out = $urandom; num_of_errors = 2'($urandom);
            end
        end

        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            operation_done = ($urandom_range(0, 1) == 0);
            data_out = $urandom;
            check("resp_valid", {31'd0, res_valid}, 32'd1);
            check("resp_data", res_data, exp_data);
            check("resp_num_err", {30'd0, res_num_err}, {30'd0, exp_nerr});
            check("resp_timeout", {31'd0, res_timeout}, {31'd0, exp_to});
            check("resp_job_ready", {31'd0, job_ready}, 32'd0);
            job_valid = (s < stall);
            res_ready = (s == stall);
        end

        @(negedge clk);
        check("post_res_valid", {31'd0, res_valid}, 32'd0);
        check("post_job_ready", {31'd0, job_ready}, 32'd1);
        check("post_psel", {31'd0, PSEL}, 32'd0);
        res_ready = 1'b0; job_valid = 1'b0; operation_done = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_job_ready", {31'd0, job_ready}, 32'd1);
        check("rst_psel", {31'd0, PSEL}, 32'd0);
        check("rst_penable", {31'd0, PENABLE}, 32'd0);
        check("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        check("rst_paddr", {12'd0, PADDR}, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_timeout", {31'd0, res_timeout}, 32'd0);
        rst = 1'b1;

        // Stray completion while idle produces no result
        @(negedge clk);
        operation_done = 1'b1; data_out = 32'hDEAD;
        @(negedge clk);
        operation_done = 1'b0;
        check("idle_done_ignored", {31'd0, res_valid}, 32'd0);

        // Directed jobs: EO, FC with one error, timeout, back-pressure, coincidence, ctrl=3, DO
        run_job(2'd0, 32'h5A, 32'h0, 32'h0, 3, 32'h1234_5678, 2'd0, 0);
        run_job(2'd2, 32'hA5, 32'h20, 32'h1, 3, 32'h0BAD_F00D, 2'd1, 0);
        run_job(2'd1, 32'h77, 32'h10, 32'h0, TIMEOUT + 5, 32'hFFFF_FFFF, 2'd2, 0);
        run_job(2'd1, 32'h99, 32'h8, 32'h0, 5, 32'hCAFE_0001, 2'd2, 10);
        run_job(2'd0, 32'h11, 32'h8, 32'h0, TIMEOUT - 1, 32'h5555_AAAA, 2'd1, 1);
        run_job(2'd3, 32'h22, 32'h10, 32'h3, 0, 32'h0000_0042, 2'd3, 0);

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            run_job(2'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, TIMEOUT + 4)),
                    $urandom, 2'($urandom), int'($urandom_range(0, 4)));
        end

        // Reset during the ACCESS phase of the second write abandons the transfer
        @(negedge clk);
        job_valid = 1'b1; job_ctrl = 2'd2; job_data = 32'h1; job_width = 32'h2; job_noise = 32'h3;
        repeat (4) begin
            @(negedge clk);
            job_valid = 1'b0;
        end
        check("pre_rst_access", {30'd0, PSEL, PENABLE}, 32'd3);
        check("pre_rst_paddr", {12'd0, PADDR}, 32'h8);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_psel", {31'd0, PSEL}, 32'd0);
        check("midrst_penable", {31'd0, PENABLE}, 32'd0);
        check("midrst_job_ready", {31'd0, job_ready}, 32'd1);
        check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_paddr", {12'd0, PADDR}, 32'd0);
        rst = 1'b1;
        run_job(2'd0, 32'hBEEF, 32'h4, 32'h0, 2, 32'h0000_BEEF, 2'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
